// File: rtl/disp_msg_sched_pkg.sv
// Shared constants and types for the display message scheduler: display modes,
// event direction, baud selects, FSM states and the FIFO entry layout.
package disp_msg_sched_pkg;

  localparam logic BAUDRATE_MODE = 1'b0;
  localparam logic DATA_MODE     = 1'b1;

  localparam logic DIR_RX = 1'b0;
  localparam logic DIR_TX = 1'b1;

  localparam logic [1:0] SEL_9600   = 2'd0;
  localparam logic [1:0] SEL_57600  = 2'd1;
  localparam logic [1:0] SEL_115200 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHOW_DATA = 2'd1,
    ST_SHOW_BAUD = 2'd2
  } state_t;

  typedef struct packed {
    logic       dir;
    logic [7:0] data;
  } evt_t;

  function automatic logic [7:0] baud_to_msg(input logic [1:0] sel);
    return {6'b0, sel};
  endfunction

endpackage

// File: rtl/disp_evt_fifo.sv
// Event FIFO with two push ports written in RX-then-TX order and one pop port.
// Callers only assert a push when a slot is available for it.
module disp_evt_fifo
  import disp_msg_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        src_clk,
  input  logic        rst_n,
  input  logic        push_rx,
  input  evt_t        rx_evt,
  input  logic        push_tx,
  input  evt_t        tx_evt,
  input  logic        pop,
  output evt_t        rd_evt,
  output logic        empty,
  output logic        full,
  output logic [AW:0] free
);

  evt_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW-1:0] tx_slot;
  logic          pop_ok;

  // TX lands behind RX when both push in the same cycle.
  assign tx_slot = wr_ptr + AW'(push_rx);
  assign pop_ok  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_rx) + AW'(push_tx);
      rd_ptr <= rd_ptr + AW'(pop_ok);
      count  <= count + (AW+1)'(push_rx) + (AW+1)'(push_tx) - (AW+1)'(pop_ok);
    end
  end

  // NOTE: storage is deliberately not reset; count and pointers alone define
  // which entries are valid, so a reset still discards every queued event.
  always_ff @(posedge src_clk) begin
    if (push_rx) mem[wr_ptr]  <= rx_evt;
    if (push_tx) mem[tx_slot] <= tx_evt;
  end

  assign rd_evt = mem[rd_ptr];
  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign free   = (AW+1)'(DEPTH) - count;

endmodule

// File: rtl/disp_msg_sched.sv
// Display message scheduler: queues UART RX/TX bytes and baud changes and holds
// each on the display for HOLD_CYCLES. Optional ovf port: DISP_MSG_OVF_FLAG_EN.
module disp_msg_sched
  import disp_msg_sched_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int DEPTH       = 4
) (
  input  logic       src_clk,
  input  logic       rst_n,
  input  logic [1:0] baud_sel,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       mode,
  output logic       data_dir,
  output logic [7:0] msg
`ifdef DISP_MSG_OVF_FLAG_EN
  ,
  output logic       ovf
`endif
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          mode_nxt, dir_nxt, pend_nxt;
  logic [7:0]    msg_nxt;
  logic          baud_pend, armed, change, load_evt;
  logic [1:0]    baud_q;

  evt_t          rx_evt, tx_evt, rd_evt;
  logic          push_rx, push_tx, pop, empty, full;
  logic [AW:0]   free;

  assign rx_evt  = '{dir: DIR_RX, data: rx_data};
  assign tx_evt  = '{dir: DIR_TX, data: tx_data};
  // Admission uses the pre-pop occupancy: RX first, TX only if a second slot remains.
  assign push_rx = rx_valid && !full;
  assign push_tx = tx_valid && (push_rx ? (free >= (AW+1)'(2)) : !full);

  disp_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .src_clk (src_clk),
    .rst_n   (rst_n),
    .push_rx (push_rx),
    .rx_evt  (rx_evt),
    .push_tx (push_tx),
    .tx_evt  (tx_evt),
    .pop     (pop),
    .rd_evt  (rd_evt),
    .empty   (empty),
    .full    (full),
    .free    (free)
  );

  assign change = armed && (baud_sel != baud_q);

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode;
    dir_nxt   = data_dir;
    msg_nxt   = msg;
    pend_nxt  = baud_pend;
    load_evt  = 1'b0;
    pop       = 1'b0;

    case (state)
      ST_IDLE: begin
        mode_nxt = BAUDRATE_MODE;
        msg_nxt  = baud_to_msg(baud_sel);
        if (change) begin
          state_nxt = ST_SHOW_BAUD;
          cnt_nxt   = HOLD_LOAD;
        end else if (!empty) begin
          load_evt = 1'b1;
        end
      end
      ST_SHOW_DATA: begin
        if (change) pend_nxt = 1'b1;
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else if (baud_pend || change) begin
          state_nxt = ST_SHOW_BAUD;
          pend_nxt  = 1'b0;
          cnt_nxt   = HOLD_LOAD;
          mode_nxt  = BAUDRATE_MODE;
          msg_nxt   = baud_to_msg(baud_sel);
        end else if (!empty) begin
          load_evt = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
          mode_nxt  = BAUDRATE_MODE;
          msg_nxt   = baud_to_msg(baud_sel);
        end
      end
      ST_SHOW_BAUD: begin
        mode_nxt = BAUDRATE_MODE;
        msg_nxt  = baud_to_msg(baud_sel);
        if (change)             cnt_nxt   = HOLD_LOAD;
        else if (cnt != '0)     cnt_nxt   = cnt - CW'(1);
        else if (!empty)        load_evt  = 1'b1;
        else                    state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (load_evt) begin
      pop       = 1'b1;
      state_nxt = ST_SHOW_DATA;
      cnt_nxt   = HOLD_LOAD;
      mode_nxt  = DATA_MODE;
      dir_nxt   = rd_evt.dir;
      msg_nxt   = rd_evt.data;
    end
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mode      <= BAUDRATE_MODE;
      data_dir  <= DIR_RX;
      msg       <= 8'h00;
      baud_pend <= 1'b0;
      baud_q    <= 2'b00;
      armed     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mode      <= mode_nxt;
      data_dir  <= dir_nxt;
      msg       <= msg_nxt;
      baud_pend <= pend_nxt;
      baud_q    <= baud_sel;
      armed     <= 1'b1;
    end
  end

`ifdef DISP_MSG_OVF_FLAG_EN
  logic drop;
  assign drop = (rx_valid && !push_rx) || (tx_valid && !push_tx);

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n)    ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_disp_msg_sched.sv
// Directed testbench for disp_msg_sched with HOLD_CYCLES=4, DEPTH=4.
// Inputs change and outputs are sampled on the falling edge of src_clk.
module tb_disp_msg_sched;

  logic       src_clk = 1'b0;
  logic       rst_n;
  logic [1:0] baud_sel;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       mode;
  logic       data_dir;
  logic [7:0] msg;
`ifdef DISP_MSG_OVF_FLAG_EN
  logic       ovf;
`endif

  int checks   = 0;
  int failures = 0;

  // {mode, data_dir, msg}; baud-mode compares ignore data_dir.
  localparam logic [9:0] M_ALL  = 10'h3FF;
  localparam logic [9:0] M_BAUD = 10'h2FF;

  disp_msg_sched #(.HOLD_CYCLES(4), .DEPTH(4)) dut (
    .src_clk  (src_clk),
    .rst_n    (rst_n),
    .baud_sel (baud_sel),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .mode     (mode),
    .data_dir (data_dir),
    .msg      (msg)
`ifdef DISP_MSG_OVF_FLAG_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 src_clk = ~src_clk;

  task automatic test_reset();
    rst_n = 1'b0; baud_sel = 2'd2;
    rx_valid = 1'b0; rx_data = 8'h00; tx_valid = 1'b0; tx_data = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(negedge src_clk);
      checks++;
      if ({mode, data_dir, msg} !== 10'h000) begin
        failures++;
        $display("FAIL reset_hold got=%h exp=%h", {mode, data_dir, msg}, 10'h000);
      end
    end
`ifdef DISP_MSG_OVF_FLAG_EN
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf got=%b exp=0", ovf);
    end
`endif
    rst_n = 1'b1;
    @(negedge src_clk);
    checks++;
    if ({mode, data_dir, msg} !== 10'h002) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", {mode, data_dir, msg}, 10'h002);
    end
  endtask

  task automatic test_single_rx();
    @(negedge src_clk);
    rx_valid = 1'b1; rx_data = 8'h41;
    @(negedge src_clk);
    rx_valid = 1'b0;
    checks++;
    if (({mode, data_dir, msg} & M_BAUD) !== 10'h002) begin
      failures++;
      $display("FAIL single_latency got=%h exp=%h", {mode, data_dir, msg}, 10'h002);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge src_clk);
      checks++;
      if ({mode, data_dir, msg} !== {1'b1, 1'b0, 8'h41}) begin
        failures++;
        $display("FAIL single_show[%0d] got=%h exp=%h", i, {mode, data_dir, msg}, {1'b1, 1'b0, 8'h41});
      end
    end
    @(negedge src_clk);
    checks++;
    if (({mode, data_dir, msg} & M_BAUD) !== 10'h002) begin
      failures++;
      $display("FAIL single_return got=%h exp=%h", {mode, data_dir, msg}, 10'h002);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp;
    logic [9:0] m;
    @(negedge src_clk);
    rx_valid = 1'b1; rx_data = 8'h31; tx_valid = 1'b1; tx_data = 8'h32;
    @(negedge src_clk);
    rx_valid = 1'b0; tx_valid = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge src_clk);
      if (c < 4)      begin exp = {1'b1, 1'b0, 8'h31}; m = M_ALL;  end
      else if (c < 8) begin exp = {1'b1, 1'b1, 8'h32}; m = M_ALL;  end
      else            begin exp = 10'h002;             m = M_BAUD; end
      checks++;
      if (({mode, data_dir, msg} & m) !== (exp & m)) begin
        failures++;
        $display("FAIL back_to_back[%0d] got=%h exp=%h", c, {mode, data_dir, msg}, exp);
      end
    end
  endtask

  task automatic test_overflow();
    logic [9:0] exp;
    logic [9:0] m;
    int idx;
    for (int c = 0; c < 24; c++) begin
      @(negedge src_clk);
      idx = (c - 2) / 4;
      if (c >= 2 && idx < 5) begin
        exp = {1'b1, 1'b0, 8'h10 + 8'(idx)}; m = M_ALL;
      end else begin
        exp = 10'h002; m = M_BAUD;
      end
      checks++;
      if (({mode, data_dir, msg} & m) !== (exp & m)) begin
        failures++;
        $display("FAIL overflow[%0d] got=%h exp=%h", c, {mode, data_dir, msg}, exp);
      end
`ifdef DISP_MSG_OVF_FLAG_EN
      checks++;
      if (ovf !== (c >= 6)) begin
        failures++;
        $display("FAIL overflow_flag[%0d] got=%b exp=%b", c, ovf, (c >= 6));
      end
`endif
      rx_valid = (c < 6);
      rx_data  = 8'h10 + 8'(c);
    end
  endtask

  task automatic test_baud_change();
    logic [9:0] exp;
    logic [9:0] m;
    @(negedge src_clk);
    baud_sel = 2'd0;
    repeat (6) @(negedge src_clk);
    checks++;
    if (({mode, data_dir, msg} & M_BAUD) !== 10'h000) begin
      failures++;
      $display("FAIL baud_settle got=%h exp=%h", {mode, data_dir, msg}, 10'h000);
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge src_clk);
      if (c < 2)       begin exp = 10'h000;             m = M_BAUD; end
      else if (c < 6)  begin exp = {1'b1, 1'b0, 8'h55}; m = M_ALL;  end
      else if (c < 10) begin exp = 10'h001;             m = M_BAUD; end
      else if (c < 14) begin exp = {1'b1, 1'b0, 8'h56}; m = M_ALL;  end
      else             begin exp = 10'h001;             m = M_BAUD; end
      checks++;
      if (({mode, data_dir, msg} & m) !== (exp & m)) begin
        failures++;
        $display("FAIL baud_change[%0d] got=%h exp=%h", c, {mode, data_dir, msg}, exp);
      end
      case (c)
        0: begin rx_valid = 1'b1; rx_data = 8'h55; end
        1: begin rx_valid = 1'b1; rx_data = 8'h56; end
        2: rx_valid = 1'b0;
        3: baud_sel = 2'd1;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      @(negedge src_clk);
      rx_valid = (c < 2); tx_valid = (c == 1);
      rx_data  = (c == 0) ? 8'h61 : 8'h62;
      tx_data  = 8'h63;
    end
    @(negedge src_clk);
    checks++;
    if ({mode, data_dir, msg} !== {1'b1, 1'b0, 8'h61}) begin
      failures++;
      $display("FAIL rst_mid_pre got=%h exp=%h", {mode, data_dir, msg}, {1'b1, 1'b0, 8'h61});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mode, data_dir, msg} !== 10'h000) begin
      failures++;
      $display("FAIL rst_mid_async got=%h exp=%h", {mode, data_dir, msg}, 10'h000);
    end
`ifdef DISP_MSG_OVF_FLAG_EN
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_ovf got=%b exp=0", ovf);
    end
`endif
    @(negedge src_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge src_clk);
      checks++;
      if ({mode, data_dir, msg} !== 10'h001) begin
        failures++;
        $display("FAIL rst_mid_after[%0d] got=%h exp=%h", i, {mode, data_dir, msg}, 10'h001);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_rx();
    test_back_to_back();
    test_overflow();
    test_baud_change();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
